// File: rtl/vid_timing_gen.sv
// Programmable raster timing generator with frame-synchronous timing updates.
// Ports: clk_pix/reset (sync, active-low), pix_en advance enable, cfg_* timing
//   inputs captured by cfg_load, cfg_pending flag, registered sx/sy position,
//   hsync/vsync/de, line_start/frame_start strobes, and frame_cnt when the
//   VTG_FRAME_CNT_EN macro is defined.
module vid_timing_gen #(
    parameter int unsigned CW         = 12,
    parameter int unsigned DEF_HA_END = 639,
    parameter int unsigned DEF_HS_STA = 655,
    parameter int unsigned DEF_HS_END = 751,
    parameter int unsigned DEF_LINE   = 799,
    parameter int unsigned DEF_VA_END = 479,
    parameter int unsigned DEF_VS_STA = 489,
    parameter int unsigned DEF_VS_END = 491,
    parameter int unsigned DEF_SCREEN = 524,
    parameter bit          DEF_HPOL   = 1'b0,
    parameter bit          DEF_VPOL   = 1'b0
) (
    input  logic          clk_pix,
    input  logic          reset,
    input  logic          pix_en,
    input  logic [CW-1:0] cfg_ha_end,
    input  logic [CW-1:0] cfg_hs_sta,
    input  logic [CW-1:0] cfg_hs_end,
    input  logic [CW-1:0] cfg_line,
    input  logic [CW-1:0] cfg_va_end,
    input  logic [CW-1:0] cfg_vs_sta,
    input  logic [CW-1:0] cfg_vs_end,
    input  logic [CW-1:0] cfg_screen,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    input  logic          cfg_load,
    output logic          cfg_pending,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
`ifdef VTG_FRAME_CNT_EN
    output logic [15:0]   frame_cnt,
`endif
    output logic          frame_start
);

    typedef struct packed {
        logic [CW-1:0] ha_end;
        logic [CW-1:0] hs_sta;
        logic [CW-1:0] hs_end;
        logic [CW-1:0] line;
        logic [CW-1:0] va_end;
        logic [CW-1:0] vs_sta;
        logic [CW-1:0] vs_end;
        logic [CW-1:0] screen;
        logic          hpol;
        logic          vpol;
    } tset_t;

    localparam tset_t DEF = '{
        ha_end: CW'(DEF_HA_END), hs_sta: CW'(DEF_HS_STA),
        hs_end: CW'(DEF_HS_END), line:   CW'(DEF_LINE),
        va_end: CW'(DEF_VA_END), vs_sta: CW'(DEF_VS_STA),
        vs_end: CW'(DEF_VS_END), screen: CW'(DEF_SCREEN),
        hpol:   DEF_HPOL,        vpol:   DEF_VPOL
    };

    tset_t cfg_in;
    tset_t act_q, act_d, pend_q, pend_d;
    logic pflag_q, pflag_d;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
    logic hwrap, vwrap, fb, hraw, vraw;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;
`endif

    assign cfg_in = '{
        ha_end: cfg_ha_end, hs_sta: cfg_hs_sta,
        hs_end: cfg_hs_end, line:   cfg_line,
        va_end: cfg_va_end, vs_sta: cfg_vs_sta,
        vs_end: cfg_vs_end, screen: cfg_screen,
        hpol:   cfg_hpol,   vpol:   cfg_vpol
    };

    always_comb begin
        // >= so counters left beyond a shrunken limit still wrap
        hwrap = hc_q >= act_q.line;
        vwrap = vc_q >= act_q.screen;
        fb    = pix_en & hwrap & vwrap;
        hraw  = (hc_q >= act_q.hs_sta) & (hc_q < act_q.hs_end);
        vraw  = (vc_q >= act_q.vs_sta) & (vc_q < act_q.vs_end);

        hc_d = hc_q;
        vc_d = vc_q;
        sx_d = sx_q;
        sy_d = sy_q;
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (pix_en) begin
            hc_d = hwrap ? '0 : hc_q + 1'b1;
            if (hwrap) begin
                vc_d = vwrap ? '0 : vc_q + 1'b1;
            end
            sx_d = hc_q;
            sy_d = vc_q;
            hs_d = ~(hraw ^ act_q.hpol);
            vs_d = ~(vraw ^ act_q.vpol);
            de_d = (hc_q <= act_q.ha_end) & (vc_q <= act_q.va_end);
            ls_d = hc_q == '0;
            fs_d = (hc_q == '0) & (vc_q == '0);
        end

        // boundary applies the previously captured set; a coincident
        // load refills pending and keeps the flag up
        act_d   = (fb & pflag_q) ? pend_q : act_q;
        pend_d  = cfg_load ? cfg_in : pend_q;
        pflag_d = cfg_load | (pflag_q & ~fb);
`ifdef VTG_FRAME_CNT_EN
        fcnt_d = fcnt_q + 16'(fb);
`endif
    end

    always_ff @(posedge clk_pix) begin
        if (!reset) begin
            act_q   <= DEF;
            pend_q  <= DEF;
            pflag_q <= 1'b0;
            hc_q    <= '0;
            vc_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            hs_q    <= ~DEF_HPOL;
            vs_q    <= ~DEF_VPOL;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
`ifdef VTG_FRAME_CNT_EN
            fcnt_q  <= '0;
`endif
        end else begin
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
`ifdef VTG_FRAME_CNT_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign cfg_pending = pflag_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
`ifdef VTG_FRAME_CNT_EN
    assign frame_cnt   = fcnt_q;
`endif

endmodule
